fetch_ir_unit: RTL and testbench
================================

// Module: fetch_ir_unit
// PURPOSE
// - Fetch-side datapath slice driven directly by the multicycle controller: PC register, PC-source mux,
//   memory address mux (iord), byte-wise 32-bit instruction register, and memory data register.
// - Decodes IR fields back to the controller (op) and the register file / ALU (rs, rt, rd, funct, imm).
// - Checks that irwrite strobes arrive in legal order and counts completed instruction fetches.
// PARAMETERS
// - WIDTH     8   datapath / address width (bits); must be >= 4
// - CNT_W     16  width of the completed-fetch counter
// - RESET_PC  0   PC value loaded on reset (WIDTH bits)
// PORTS
// - clk         in   1      single clock; all state updates on the rising edge
// - reset_n     in   1      asynchronous, active-low reset
// - pcen        in   1      PC write enable from the controller
// - pcsource    in   2      00 aluresult, 01 aluout, 10 jump target, 11 illegal
// - iord        in   1      0: adr = pc; 1: adr = aluout
// - memread     in   1      load mdr from memdata this cycle
// - irwrite     in   4      one-hot IR byte enable; bit k loads memdata into instr[8k+7:8k]
// - memdata     in   WIDTH  read data from memory
// - aluresult   in   WIDTH  combinational ALU result
// - aluout      in   WIDTH  registered ALU result
// - adr         out  WIDTH  memory address (combinational)
// - pc          out  WIDTH  current PC
// - instr       out  32     instruction register
// - op          out  6      instr[31:26], to controller
// - rs,rt,rd    out  5      instr[25:21], instr[20:16], instr[15:11]
// - funct       out  6      instr[5:0]
// - imm         out  16     instr[15:0]
// - mdr         out  WIDTH  memory data register
// - ir_valid    out  1      all four IR bytes loaded in order since the last irwrite[0]
// - ir_seq_err  out  1      sticky: illegal irwrite pattern seen
// - pc_src_err  out  1      sticky: pcen with pcsource == 11 seen
// - fetch_cnt   out  CNT_W  completed fetches, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset (reset_n low, asynchronous): pc=RESET_PC, instr=0, mdr=0, ir_valid=0, exp_byte=0,
//   ir_seq_err=0, pc_src_err=0, fetch_cnt=0. adr follows pc while in reset (iord permitting).
// - PC: when pcen=1, next pc = aluresult | aluout | {instr[WIDTH-3:0],2'b00} per pcsource. 
//   pcsource=11 with pcen=1: pc holds; pc_src_err set. pcen=0: pc holds; pcsource is ignored.
// - adr = iord ? aluout : pc; purely combinational, zero latency.
// - mdr <= memdata when memread=1, else holds. One-cycle latency.
// - IR: for each k with irwrite[k]=1, load byte k from memdata, even when the pattern is illegal.
// - Sequence tracker (exp_byte, 2 bits):
//   - irwrite == 0: no change.
//   - irwrite == 0001: restart. ir_valid<=0, exp_byte<=1, regardless of the current exp_byte.
//   - irwrite == one-hot bit exp_byte (exp_byte 1..3): advance. On byte 3: ir_valid<=1, exp_byte<=0,
//     fetch_cnt<=fetch_cnt+1 (wraps to 0).
//   - any other nonzero pattern (multi-hot, or out of order): ir_seq_err<=1, ir_valid<=0, exp_byte<=0.
// - ir_valid stays high until the next irwrite[0]; IR fields are meaningful only while ir_valid=1.
// - Both error flags are sticky until reset.
// - Simultaneous pcen and irwrite in one cycle: both take effect. The jump target uses the pre-edge instr.
// - Reset asserted mid-fetch: the partial IR is discarded (instr=0), and the next fetch must restart with byte 0.
// STRUCTURE
// - Shared package: localparams PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10; IR field bit positions.
// - One sub-module, ir_seq_tracker: owns exp_byte, ir_valid, ir_seq_err, fetch_cnt. Parameters: CNT_W.
// - The PC, mdr, IR byte registers and muxes sit at the top level.
// TESTING
// - Reset: reset_n=0 mid-cycle -> pc=00, instr=0, fetch_cnt=0 immediately. With iord=0, adr=00.
// - Legal fetch: irwrite 1,2,4,8 with memdata 0x20,0x00,0x04,0x8C -> instr=0x8C040020, op=6'h23,
//   ir_valid=1 after the 4th edge, fetch_cnt=1.
// - Out-of-order fetch: irwrite 1 then 4 -> ir_seq_err=1, ir_valid=0. A following legal 1,2,4,8 sequence
//   gives ir_valid=1 while ir_seq_err stays 1.
// - PC sources: pc=04, pcen with pcsource=00 and aluresult=08 -> pc=08. With instr[5:0]=6'h05 and
//   pcsource=10 -> pc=0x14. With pcsource=11 -> pc holds and pc_src_err=1.
// - Address/MDR: iord=1, aluout=0x3C -> adr=0x3C. memread with memdata=0xA5 -> mdr=0xA5 on the next edge;
//   memread=0 -> mdr holds.
// - Counter wrap: with CNT_W=2, complete 4 fetches -> fetch_cnt goes 1,2,3,0.

Source files
------------

// File: rtl/fetch_ir_unit_pkg.sv
// Shared types and constants for the fetch / instruction-register datapath slice.
package fetch_ir_unit_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    EXP_B0 = 2'd0,
    EXP_B1 = 2'd1,
    EXP_B2 = 2'd2,
    EXP_B3 = 2'd3
  } exp_byte_e;

  function automatic logic [3:0] byte_strobe(input exp_byte_e b);
    return 4'b0001 << b;
  endfunction

endpackage

// File: rtl/fetch_ir_unit_ir_seq_tracker.sv
// Checks that IR byte strobes arrive in order 0,1,2,3 and counts completed fetches.
//   state  | meaning
//   EXP_B0 | idle: no fetch in progress, only byte 0 is legal
//   EXP_B1 | byte 0 loaded, byte 1 expected
//   EXP_B2 | bytes 0-1 loaded, byte 2 expected
//   EXP_B3 | bytes 0-2 loaded, byte 3 completes the fetch
module ir_seq_tracker
  import fetch_ir_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       irwrite,
  output logic             ir_valid,
  output logic             ir_seq_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  exp_byte_e        exp_byte_q;
  logic             ir_valid_q;
  logic             ir_seq_err_q;
  logic [CNT_W-1:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_byte_q   <= EXP_B0;
      ir_valid_q   <= 1'b0;
      ir_seq_err_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else if (irwrite != 4'b0000) begin
      // byte 0 always restarts, even mid-fetch or after an error
      if (irwrite == 4'b0001) begin
        ir_valid_q <= 1'b0;
        exp_byte_q <= EXP_B1;
      end else if (exp_byte_q != EXP_B0 && irwrite == byte_strobe(exp_byte_q)) begin
        if (exp_byte_q == EXP_B3) begin
          ir_valid_q  <= 1'b1;
          exp_byte_q  <= EXP_B0;
          fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
        end else begin
          exp_byte_q <= exp_byte_e'(exp_byte_q + 2'd1);
        end
      end else begin
        ir_seq_err_q <= 1'b1;
        ir_valid_q   <= 1'b0;
        exp_byte_q   <= EXP_B0;
      end
    end
  end

  assign ir_valid   = ir_valid_q;
  assign ir_seq_err = ir_seq_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: rtl/fetch_ir_unit.sv
// Fetch-side datapath: PC with source mux, memory address mux, byte-wise IR, MDR,
// IR field decode and the IR load-order tracker.
module fetch_ir_unit
  import fetch_ir_unit_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pcen,
  input  logic [1:0]       pcsource,
  input  logic             iord,
  input  logic             memread,
  input  logic [3:0]       irwrite,
  input  logic [WIDTH-1:0] memdata,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic [15:0]      imm,
  output logic [WIDTH-1:0] mdr,
  output logic             ir_valid,
  output logic             ir_seq_err,
  output logic             pc_src_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [31:0]      instr_q, instr_d;
  logic             pc_src_err_q, pc_src_err_d;
  logic [7:0]       mem_byte;

  // IR bytes are always 8 bits wide regardless of the datapath width
  assign mem_byte = 8'(memdata);

  always_comb begin
    pc_d         = pc_q;
    pc_src_err_d = pc_src_err_q;
    if (pcen) begin
      case (pcsource)
        PCSRC_ALU:    pc_d = aluresult;
        PCSRC_ALUOUT: pc_d = aluout;
        PCSRC_JUMP:   pc_d = {instr_q[WIDTH-3:0], 2'b00};
        default:      pc_src_err_d = 1'b1;
      endcase
    end

    mdr_d = memread ? memdata : mdr_q;

    instr_d = instr_q;
    for (int k = 0; k < 4; k++) begin
      if (irwrite[k]) instr_d[8*k +: 8] = mem_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= RESET_PC;
      mdr_q        <= '0;
      instr_q      <= '0;
      pc_src_err_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      mdr_q        <= mdr_d;
      instr_q      <= instr_d;
      pc_src_err_q <= pc_src_err_d;
    end
  end

  ir_seq_tracker #(.CNT_W(CNT_W)) u_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .irwrite    (irwrite),
    .ir_valid   (ir_valid),
    .ir_seq_err (ir_seq_err),
    .fetch_cnt  (fetch_cnt)
  );

  assign adr        = iord ? aluout : pc_q;
  assign pc         = pc_q;
  assign mdr        = mdr_q;
  assign instr      = instr_q;
  assign pc_src_err = pc_src_err_q;
  assign op         = instr_q[OP_LSB +: 6];
  assign rs         = instr_q[RS_LSB +: 5];
  assign rt         = instr_q[RT_LSB +: 5];
  assign rd         = instr_q[RD_LSB +: 5];
  assign funct      = instr_q[FUNCT_LSB +: 6];
  assign imm        = instr_q[IMM_LSB +: 16];

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Self-checking bench for fetch_ir_unit: directed scenarios plus a randomized run
// against a behavioural model of the PC, MDR, IR and fetch-order rules.
module tb_fetch_ir_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pcen = 1'b0, iord = 1'b0, memread = 1'b0;
  logic [1:0] pcsource = 2'b00;
  logic [3:0] irwrite = 4'b0000;
  logic [7:0] memdata = '0, aluresult = '0, aluout = '0;

  logic [7:0]  adr, pc, mdr;
  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        ir_valid, ir_seq_err, pc_src_err;
  logic [1:0]  fetch_cnt;

  fetch_ir_unit #(.WIDTH(8), .CNT_W(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .pcen(pcen), .pcsource(pcsource), .iord(iord),
    .memread(memread), .irwrite(irwrite), .memdata(memdata), .aluresult(aluresult),
    .aluout(aluout), .adr(adr), .pc(pc), .instr(instr), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .funct(funct), .imm(imm), .mdr(mdr), .ir_valid(ir_valid),
    .ir_seq_err(ir_seq_err), .pc_src_err(pc_src_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: bytes loaded since the last byte-0 restart are kept as a list
  logic [7:0]  m_pc, m_mdr;
  logic [31:0] m_instr;
  logic        m_valid, m_err, m_pcerr;
  int          m_cnt;
  int          seq[$];

  function automatic void model_reset();
    m_pc = 8'h00; m_mdr = 8'h00; m_instr = 32'h0;
    m_valid = 1'b0; m_err = 1'b0; m_pcerr = 1'b0; m_cnt = 0;
    seq.delete();
  endfunction

  function automatic void model_step();
    int idx;
    if (pcen) begin
      case (pcsource)
        2'b00:   m_pc = aluresult;
        2'b01:   m_pc = aluout;
        2'b10:   m_pc = 8'((m_instr * 4) % 256);
        default: m_pcerr = 1'b1;
      endcase
    end
    if (memread) m_mdr = memdata;
    for (int k = 0; k < 4; k++)
      if (irwrite[k]) m_instr[8*k +: 8] = memdata;
    if (irwrite != 4'b0000) begin
      if ($countones(irwrite) != 1) begin
        m_err = 1'b1; m_valid = 1'b0; seq.delete();
      end else begin
        idx = $clog2(irwrite);
        if (idx == 0) begin
          seq.delete(); seq.push_back(0); m_valid = 1'b0;
        end else if (seq.size() >= 1 && seq.size() <= 3 && idx == seq.size()) begin
          seq.push_back(idx);
          if (seq.size() == 4) begin
            m_valid = 1'b1; m_cnt = (m_cnt + 1) % 4;
          end
        end else begin
          m_err = 1'b1; m_valid = 1'b0; seq.delete();
        end
      end
    end
  endfunction

  task automatic apply(input logic pe, input logic [1:0] ps, input logic io, input logic mr,
                       input logic [3:0] iw, input logic [7:0] md, input logic [7:0] ar,
                       input logic [7:0] ao);
    pcen = pe; pcsource = ps; iord = io; memread = mr; irwrite = iw;
    memdata = md; aluresult = ar; aluout = ao;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(0, 2'b00, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 2'b00, 0, 1, 4'b0001, 8'h5A, 8'h44, 8'h00);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (pc !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_cmp++; if (fetch_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    n_cmp++; if (adr !== 8'h00) begin n_bad++; $display("FAIL reset_adr: got %h want 00", adr); end
    n_cmp++; if ({mdr, ir_valid, ir_seq_err, pc_src_err} !== 11'h0) begin
      n_bad++; $display("FAIL reset_flags: mdr=%h v=%b se=%b pe=%b want all 0", mdr, ir_valid, ir_seq_err, pc_src_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    apply(0, 2'b00, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_legal_fetch();
    logic [7:0] bytes [4] = '{8'h20, 8'h00, 8'h04, 8'h8C};
    for (int k = 0; k < 4; k++) begin
      apply(0, 2'b00, 0, 0, 4'b0001 << k, bytes[k], 8'h00, 8'h00);
      if (k == 2) begin
        n_cmp++; if (ir_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_valid_early: got %b want 0", ir_valid); end
      end
    end
    n_cmp++; if (instr !== 32'h8C040020) begin n_bad++; $display("FAIL fetch_instr: got %h want 8c040020", instr); end
    n_cmp++; if (op !== 6'h23) begin n_bad++; $display("FAIL fetch_op: got %h want 23", op); end
    n_cmp++; if ({rs, rt, funct, imm} !== {5'd0, 5'd4, 6'h20, 16'h0020}) begin
      n_bad++; $display("FAIL fetch_fields: rs=%h rt=%h funct=%h imm=%h want 0 4 20 0020", rs, rt, funct, imm);
    end
    n_cmp++; if (ir_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_valid: got %b want 1", ir_valid); end
    n_cmp++; if (fetch_cnt !== 2'd1) begin n_bad++; $display("FAIL fetch_cnt: got %0d want 1", fetch_cnt); end
  endtask

  task automatic test_out_of_order();
    apply(0, 2'b00, 0, 0, 4'b0001, 8'h11, 8'h00, 8'h00);
    apply(0, 2'b00, 0, 0, 4'b0100, 8'h33, 8'h00, 8'h00);
    n_cmp++; if ({ir_seq_err, ir_valid} !== 2'b10) begin
      n_bad++; $display("FAIL ooo_err: err=%b valid=%b want 1 0", ir_seq_err, ir_valid);
    end
    for (int k = 0; k < 4; k++) apply(0, 2'b00, 0, 0, 4'b0001 << k, 8'(k + 1), 8'h00, 8'h00);
    n_cmp++; if ({ir_seq_err, ir_valid} !== 2'b11) begin
      n_bad++; $display("FAIL ooo_recover: err=%b valid=%b want 1 1", ir_seq_err, ir_valid);
    end
    n_cmp++; if (instr !== 32'h04030201) begin n_bad++; $display("FAIL ooo_instr: got %h want 04030201", instr); end
    apply(0, 2'b00, 0, 0, 4'b0011, 8'h00, 8'h00, 8'h00);
    n_cmp++; if ({ir_seq_err, ir_valid} !== 2'b10) begin
      n_bad++; $display("FAIL multihot: err=%b valid=%b want 1 0", ir_seq_err, ir_valid);
    end
  endtask

  task automatic test_pc_sources();
    do_reset();
    apply(1, 2'b00, 0, 0, 4'b0000, 8'h00, 8'h04, 8'h00);
    n_cmp++; if (pc !== 8'h04) begin n_bad++; $display("FAIL pc_init: got %h want 04", pc); end
    apply(1, 2'b00, 0, 0, 4'b0000, 8'h00, 8'h08, 8'h99);
    n_cmp++; if (pc !== 8'h08) begin n_bad++; $display("FAIL pc_alu: got %h want 08", pc); end
    apply(0, 2'b11, 0, 0, 4'b0001, 8'h05, 8'h77, 8'h66);
    n_cmp++; if ({pc, pc_src_err} !== {8'h08, 1'b0}) begin
      n_bad++; $display("FAIL pc_hold: pc=%h err=%b want 08 0", pc, pc_src_err);
    end
    apply(1, 2'b01, 0, 0, 4'b0000, 8'h00, 8'h00, 8'h2C);
    n_cmp++; if (pc !== 8'h2C) begin n_bad++; $display("FAIL pc_aluout: got %h want 2c", pc); end
    // jump and a new byte 0 in the same cycle: the jump must see the old byte
    apply(1, 2'b10, 0, 0, 4'b0001, 8'h3F, 8'h00, 8'h00);
    n_cmp++; if (pc !== 8'h14) begin n_bad++; $display("FAIL pc_jump: got %h want 14", pc); end
    apply(1, 2'b11, 0, 0, 4'b0000, 8'h00, 8'h77, 8'h66);
    n_cmp++; if ({pc, pc_src_err} !== {8'h14, 1'b1}) begin
      n_bad++; $display("FAIL pc_illegal: pc=%h err=%b want 14 1", pc, pc_src_err);
    end
    apply(1, 2'b00, 0, 0, 4'b0000, 8'h00, 8'h50, 8'h00);
    n_cmp++; if ({pc, pc_src_err} !== {8'h50, 1'b1}) begin
      n_bad++; $display("FAIL pc_err_sticky: pc=%h err=%b want 50 1", pc, pc_src_err);
    end
  endtask

  task automatic test_adr_mdr();
    iord = 1'b1; aluout = 8'h3C;
    #1;
    n_cmp++; if (adr !== 8'h3C) begin n_bad++; $display("FAIL adr_iord: got %h want 3c", adr); end
    apply(0, 2'b00, 1, 1, 4'b0000, 8'hA5, 8'h00, 8'h3C);
    n_cmp++; if (mdr !== 8'hA5) begin n_bad++; $display("FAIL mdr_load: got %h want a5", mdr); end
    apply(0, 2'b00, 0, 0, 4'b0000, 8'h5A, 8'h00, 8'h3C);
    n_cmp++; if (mdr !== 8'hA5) begin n_bad++; $display("FAIL mdr_hold: got %h want a5", mdr); end
    n_cmp++; if (adr !== m_pc) begin n_bad++; $display("FAIL adr_pc: got %h want %h", adr, m_pc); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      for (int k = 0; k < 4; k++) apply(0, 2'b00, 0, 0, 4'b0001 << k, 8'($urandom), 8'h00, 8'h00);
      n_cmp++; if ({ir_valid, fetch_cnt} !== {1'b1, 2'(f % 4)}) begin
        n_bad++; $display("FAIL cnt_wrap%0d: valid=%b cnt=%0d want 1 %0d", f, ir_valid, fetch_cnt, f % 4);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    apply(0, 2'b00, 0, 0, 4'b0001, 8'hDE, 8'h00, 8'h00);
    apply(0, 2'b00, 0, 0, 4'b0010, 8'hAD, 8'h00, 8'h00);
    do_reset();
    n_cmp++; if ({instr, ir_valid} !== 33'h0) begin
      n_bad++; $display("FAIL midreset_instr: instr=%h valid=%b want 0 0", instr, ir_valid);
    end
    apply(0, 2'b00, 0, 0, 4'b0100, 8'hBE, 8'h00, 8'h00);
    n_cmp++; if (ir_seq_err !== 1'b1) begin n_bad++; $display("FAIL midreset_restart: err=%b want 1", ir_seq_err); end
  endtask

  task automatic test_random();
    logic [3:0] iw;
    int r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      if (r < 3) iw = 4'b0000;
      else if (r == 3) iw = 4'b0001;
      else if (r < 8) iw = (seq.size() >= 1 && seq.size() <= 3) ? 4'(1 << seq.size()) : 4'b0001;
      else iw = 4'($urandom_range(1, 15));
      apply(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 12) / 4 + ($urandom_range(0, 20) == 0)),
            1'($urandom), 1'($urandom), iw, 8'($urandom), 8'($urandom), 8'($urandom));
      n_cmp++; if ({pc, instr, mdr} !== {m_pc, m_instr, m_mdr}) begin
        n_bad++; $display("FAIL rnd_data c%0d: pc=%h instr=%h mdr=%h want %h %h %h", c, pc, instr, mdr, m_pc, m_instr, m_mdr);
      end
      n_cmp++; if ({ir_valid, ir_seq_err, pc_src_err, fetch_cnt} !== {m_valid, m_err, m_pcerr, 2'(m_cnt)}) begin
        n_bad++; $display("FAIL rnd_flags c%0d: v=%b se=%b pe=%b cnt=%0d want %b %b %b %0d", c, ir_valid, ir_seq_err,
                          pc_src_err, fetch_cnt, m_valid, m_err, m_pcerr, m_cnt);
      end
      n_cmp++; if (adr !== (iord ? aluout : m_pc)) begin
        n_bad++; $display("FAIL rnd_adr c%0d: got %h want %h", c, adr, iord ? aluout : m_pc);
      end
    end
  endtask

  initial begin
    model_reset();
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_legal_fetch();
    test_out_of_order();
    test_pc_sources();
    test_adr_mdr();
    test_counter_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
